// File: rtl/npc_fetch_unit.sv
// F-stage next-PC generator: owns the fetch PC, issues valid/ready fetch requests,
// and applies D-stage redirects, exception entry and a one-entry pending redirect.
module npc_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0]    EXC_PC   = 32'h0000_4180,
  parameter int unsigned          PC_INC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        npc_op,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic              cmp_true,
  input  logic [ADDR_W-1:0] reg_data,
  input  logic [ADDR_W-1:0] epc,
  input  logic              exc_req,
  input  logic              f_req_ready,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_req_valid,
  output logic              pend_valid,
  output logic              f_pc_misaligned
);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_J    = 3'd2,
    OP_JR   = 3'd3,
    OP_ERET = 3'd4
  } npc_op_e;

  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] seq_t;
  logic [ADDR_W-1:0] br_t;
  logic [ADDR_W-1:0] j_t;
  logic [ADDR_W-1:0] redir_t;
  logic              redir;
  logic              adv;

  assign adv             = f_req_valid & f_req_ready & ~stall;
  assign f_pc_misaligned = (f_pc[1:0] != 2'b00);

  always_comb begin
    seq_t   = f_pc + ADDR_W'(PC_INC);
    br_t    = d_pc + ADDR_W'(4) + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    j_t     = {d_pc[ADDR_W-1:28], imm26, 2'b00};
    redir   = 1'b0;
    redir_t = '0;
    case (npc_op)
      OP_BR: begin
        redir   = cmp_true;
        redir_t = br_t;
      end
      OP_J: begin
        redir   = 1'b1;
        redir_t = j_t;
      end
      OP_JR: begin
        redir   = 1'b1;
        redir_t = reg_data;
      end
      OP_ERET: begin
        redir   = 1'b1;
        redir_t = epc;
      end
      default: begin
        redir   = 1'b0;
        redir_t = '0;
      end
    endcase
    redir = redir & ~stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc        <= RESET_PC;
      f_req_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      f_req_valid <= 1'b1;
      if (exc_req) begin
        f_pc       <= EXC_PC;
        pend_valid <= 1'b0;
      end else if (adv) begin
        if (pend_valid) begin
          // Draining the slot; a same-cycle redirect belongs to the next instruction.
          f_pc       <= pend_target;
          pend_valid <= redir;
          if (redir) pend_target <= redir_t;
        end else if (redir) begin
          f_pc <= redir_t;
        end else begin
          f_pc <= seq_t;
        end
      end else if (redir) begin
        pend_target <= redir_t;
        pend_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/npc_fetch_unit.md
Name: npc_fetch_unit

Overview:
- Parametrised next-PC generator for the 5-stage MIPS core. It owns the F-stage PC register and issues fetch requests to instruction memory over a valid/ready handshake.
- It applies D-stage branch, jump, jr and eret redirects, and exception entry.
- A one-entry pending-redirect buffer holds a redirect that arrives while instruction memory is not accepting, so the D stage can advance without losing it.

Parameters:
- ADDR_W, 32, PC width; must be >= 32. Bits above 31 follow the same rules as bits 31:28.
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- EXC_PC, 32'h0000_4180, exception handler entry address.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; holds F and D
- npc_op  in  3  D-stage op: 0 SEQ, 1 BR, 2 J, 3 JR, 4 ERET, 5-7 treated as SEQ
- d_pc  in  ADDR_W  PC of the instruction in D
- imm16  in  16  branch offset in words
- imm26  in  26  jump index
- cmp_true  in  1  branch condition from CMP
- reg_data  in  ADDR_W  forwarded rs value, used by JR
- epc  in  ADDR_W  EPC from CP0
- exc_req  in  1  exception or interrupt entry request
- f_req_ready  in  1  instruction memory accepts the request
- f_pc  out  ADDR_W  current fetch PC
- f_req_valid  out  1  fetch request valid
- pend_valid  out  1  pending redirect buffered
- f_pc_misaligned  out  1  f_pc[1:0] != 0 (AdEL to CP0)

Behaviour:
- Reset (synchronous):
  - f_pc = RESET_PC; f_req_valid = 0 while reset is high; pend_valid = 0; pending target = 0.
  - f_req_valid is 1 from the first cycle after reset falls and stays 1.
- Handshake: adv = f_req_valid & f_req_ready & ~stall. f_pc changes only on adv or on exc_req. f_pc and f_req_valid must remain stable while f_req_valid=1 and f_req_ready=0.
- Target computation (combinational, ADDR_W bits, wrap modulo 2^ADDR_W):
  - seq_t = f_pc + PC_INC
  - br_t = d_pc + 4 + (sign-extended imm16 << 2)
  - j_t = {d_pc[ADDR_W-1:28], imm26, 2'b00}
  - jr_t = reg_data
  - eret_t = epc
- Redirect request: redir = ~stall & (npc_op==J | npc_op==JR | npc_op==ERET | (npc_op==BR & cmp_true)). The target is the matching *_t value. A BR that is not taken is not a redirect.
- Next-PC priority when f_pc updates: exc_req > pend_valid (pending target) > redir (D target) > seq_t.
- Exception:
  - exc_req=1 forces f_pc <= EXC_PC at the next edge, independent of stall and f_req_ready.
  - It also clears pend_valid.
  - If adv is 0 in that cycle, the request restarts at EXC_PC (the abandoned request is dropped by the memory side).
- Pending buffer:
  - redir=1 and f_req_ready=0 (so adv=0): load the pending target and set pend_valid=1. A newer redir in a later waiting cycle overwrites it.
  - On adv with pend_valid=1: f_pc <= pending target, pend_valid <= 0. A simultaneous redir is also applied to the pending slot, which is the later instruction's redirect, and pend_valid stays 1. This case only occurs for ERET; other redirects cannot be back-to-back.
- Stall: stall=1 holds f_pc and pend_valid; npc_op is ignored because D re-presents it.
- f_pc_misaligned is combinational from f_pc. The PC is still issued; CP0 flushes.
- Reset asserted mid-operation overrides everything, including exc_req and a pending redirect.

Test Plan:
- Sequential fetch: release reset, f_req_ready=1, npc_op=SEQ → f_req_valid=1, f_pc sequence 0x3000, 0x3004, 0x3008.
- Branch:
  - d_pc=0x3004, BR, imm16=0xFFFF, cmp_true=1 → next f_pc=0x3004.
  - Same with cmp_true=0 and f_pc=0x3008 → 0x300C.
- Jump: d_pc=0x3008, J, imm26=0x0000C40 → f_pc=0x00003100. ERET with epc=0x3010 → f_pc=0x3010.
- Pending buffer:
  - JR with reg_data=0x3400 while f_req_ready=0 → pend_valid=1, f_pc held for 2 cycles.
  - Then f_req_ready=1 → f_pc=0x3400, pend_valid=0.
- Exception priority:
  - exc_req=1 with stall=1 and pend_valid=1 → f_pc=0x4180 next edge, pend_valid=0.
  - stall=1 alone with a J presented → f_pc unchanged.
- Reset mid-operation: assert reset while pend_valid=1 and f_pc=0x3400 → f_pc=0x3000, pend_valid=0, f_req_valid=0 until reset falls. Then jr_t=0x3402 → f_pc_misaligned=1.
